// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: turns a layer descriptor into the PE-array control bundle for one start/done job.
module pe_array_sequencer #(
  parameter int N_PE   = 8,
  parameter int ADDR_W = 10,
  parameter int ROWS_W = 10,
  parameter int BANK_W = 6,
  parameter int NL_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cfg_mode,
  input  logic [$clog2(N_PE):0]      cfg_filter_size,
  input  logic [ADDR_W-1:0]          cfg_row_length,
  input  logic [ROWS_W-1:0]          cfg_num_rows,
  input  logic [BANK_W-1:0]          cfg_num_banks,
  input  logic [NL_W-1:0]            cfg_nl_type,
  input  logic [2:0]                 cfg_pool_nl,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic [N_PE*N_PE-1:0]       shifting_line,
  output logic [N_PE*N_PE-1:0]       shifting_filter,
  output logic [N_PE*N_PE-1:0]       mac_enable,
  output logic [N_PE-1:0]            adder_enable,
  output logic [N_PE-1:0]            nl_enable,
  output logic [N_PE-1:0]            feedback_enable,
  output logic                       line_buffer_reset,
  output logic                       line_buffer_reset_pool,
  output logic                       shifting_line_pool,
  output logic                       pool_enable,
  output logic                       final_filter_bank,
  output logic [ADDR_W-1:0]          row_length,
  output logic [ADDR_W-1:0]          row_length_pool,
  output logic [NL_W-1:0]            nl_type,
  output logic [2:0]                 pool_nl
);
  localparam int KW = $clog2(N_PE) + 1;
  localparam int NN = N_PE * N_PE;
  typedef enum logic [2:0] {IDLE, CLR, LOAD_F, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d, err_q, err_d;
  logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] rl_q, rl_d, col_q, col_d;
  logic [ROWS_W-1:0] nr_q, nr_d, row_q, row_d;
  logic [BANK_W-1:0] nb_q, nb_d, bank_q, bank_d;
  logic [NL_W-1:0] nlt_q, nlt_d;
  logic [2:0] pnl_q, pnl_d;
  logic [N_PE-2:0][NN-1:0] dly_q, dly_d;
  logic [N_PE-1:0] ae_q, ae_d;
  logic [NN-1:0] amask;
  logic bad, pix;
  assign bad = cfg_row_length == '0 || cfg_num_rows == '0 || cfg_num_banks == '0 || cfg_filter_size == '0;
  assign pix = state_q == RUN && in_valid;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    k_d = k_q;
    rl_d = rl_q;
    nr_d = nr_q;
    nb_d = nb_q;
    nlt_d = nlt_q;
    pnl_d = pnl_q;
    cnt_d = cnt_q;
    col_d = col_q;
    row_d = row_q;
    bank_d = bank_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (bad) err_d = 1'b1;
        else begin
          state_d = CLR;
          mode_d = cfg_mode;
          k_d = cfg_filter_size > KW'(N_PE) ? KW'(N_PE) : cfg_filter_size;
          rl_d = cfg_row_length;
          nr_d = cfg_num_rows;
          nb_d = cfg_mode ? BANK_W'(1) : cfg_num_banks;
          nlt_d = cfg_nl_type;
          pnl_d = cfg_pool_nl;
          cnt_d = '0;
          col_d = '0;
          row_d = '0;
          bank_d = '0;
        end
      end
      CLR: state_d = mode_q ? RUN : LOAD_F;
      LOAD_F: begin
        cnt_d = cnt_q == k_q - KW'(1) ? '0 : cnt_q + KW'(1);
        state_d = cnt_q == k_q - KW'(1) ? RUN : LOAD_F;
      end
      RUN: if (in_valid) begin
        col_d = col_q == rl_q - ADDR_W'(1) ? '0 : col_q + ADDR_W'(1);
        if (col_q == rl_q - ADDR_W'(1)) begin
          row_d = row_q == nr_q - ROWS_W'(1) ? '0 : row_q + ROWS_W'(1);
          state_d = row_q == nr_q - ROWS_W'(1) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + KW'(1);
        if (cnt_q == KW'(N_PE)) begin
          cnt_d = '0;
          bank_d = bank_q == nb_q - BANK_W'(1) ? bank_q : bank_q + BANK_W'(1);
          state_d = bank_q == nb_q - BANK_W'(1) ? DONE : LOAD_F;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Row r of mac_enable sees shifting_line r cycles late; dly_q[d] holds it d+1 cycles late.
  always_comb begin
    amask = '0;
    for (int r = 0; r < N_PE; r++)
      for (int c = 0; c < N_PE; c++)
        amask[r*N_PE+c] = r < int'(k_q) && c < int'(k_q);
    dly_d[0] = shifting_line;
    for (int i = 1; i < N_PE - 1; i++) dly_d[i] = dly_q[i-1];
    mac_enable = '0;
    mac_enable[N_PE-1:0] = shifting_line[N_PE-1:0];
    for (int r = 1; r < N_PE; r++) mac_enable[r*N_PE +: N_PE] = dly_q[r-1][r*N_PE +: N_PE];
    ae_d = '0;
    for (int r = 0; r < N_PE; r++)
      if (r == int'(k_q) - 1) ae_d = mac_enable[r*N_PE +: N_PE];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      err_q <= 1'b0;
      k_q <= '0;
      cnt_q <= '0;
      rl_q <= '0;
      col_q <= '0;
      nr_q <= '0;
      row_q <= '0;
      nb_q <= '0;
      bank_q <= '0;
      nlt_q <= '0;
      pnl_q <= '0;
      dly_q <= '0;
      ae_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      err_q <= err_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      rl_q <= rl_d;
      col_q <= col_d;
      nr_q <= nr_d;
      row_q <= row_d;
      nb_q <= nb_d;
      bank_q <= bank_d;
      nlt_q <= nlt_d;
      pnl_q <= pnl_d;
      dly_q <= dly_d;
      ae_q <= ae_d;
    end
  end
  assign in_ready = state_q == RUN;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign cfg_err = err_q;
  assign shifting_line = pix && !mode_q ? amask : '0;
  assign shifting_filter = state_q == LOAD_F ? amask : '0;
  assign adder_enable = ae_q;
  assign final_filter_bank = busy && bank_q == nb_q - BANK_W'(1);
  assign feedback_enable = bank_q != '0 ? ae_q : '0;
  assign nl_enable = final_filter_bank ? ae_q : '0;
  assign line_buffer_reset = state_q == CLR && !mode_q;
  assign line_buffer_reset_pool = state_q == CLR && mode_q;
  assign shifting_line_pool = pix && mode_q;
  assign pool_enable = pix && mode_q;
  assign row_length = rl_q;
  assign row_length_pool = rl_q;
  assign nl_type = nlt_q;
  assign pool_nl = pnl_q;
endmodule
